// File: rtl/bm_cg_ctrl.sv
// Phase-to-(cos, sin) sequencer: folds a 16-bit phase into the first quadrant,
// interpolates two shared-ROM lookups and applies quadrant signs.
// Build option: define BM_CG_CTRL_ROUND_EN for a round-half-up interpolation term.
module bm_cg_ctrl (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [15:0]        in_phase,
  output logic [6:0]         rom_addr,
  input  logic [30:0]        rom_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [19:0] out_cos,
  output logic signed [19:0] out_sin
);

`ifdef BM_CG_CTRL_ROUND_EN
  localparam logic [18:0] RoundBias = 19'd64;
`else
  localparam logic [18:0] RoundBias = 19'd0;
`endif

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOOK0 = 3'd1,
    LOOK1 = 3'd2,
    CAP   = 3'd3,
    CALC  = 3'd4,
    DONE  = 3'd5
  } state_e;

  // ROM entry {19-bit base, 12-bit drop}; the drop is the fall across one
  // 128-step segment, so base - drop*frac/128 never goes negative.
  function automatic logic [19:0] interp(input logic [30:0] entry,
                                         input logic [6:0]  frac);
    logic [18:0] prod;
    logic [18:0] term;
    prod = 19'(entry[11:0]) * 19'(frac);
    term = (prod + RoundBias) >> 7;
    return {1'b0, entry[30:12] - term};
  endfunction

  state_e      state_q, state_d;
  logic [1:0]  quad_q, quad_d;
  logic [6:0]  x_lo_q, x_lo_d;
  logic [13:0] xc_q, xc_d;
  logic [6:0]  rom_addr_q, rom_addr_d;
  logic [30:0] ent_a_q, ent_a_d;
  logic [30:0] ent_b_q, ent_b_d;
  logic [19:0] cos_q, cos_d;
  logic [19:0] sin_q, sin_d;
  logic [19:0] f_x, f_xc;

  assign f_x  = interp(ent_a_q, x_lo_q);
  assign f_xc = interp(ent_b_q, xc_q[6:0]);

  // NOTE: every variable gets its hold value first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d    = state_q;
    quad_d     = quad_q;
    x_lo_d     = x_lo_q;
    xc_d       = xc_q;
    rom_addr_d = rom_addr_q;
    ent_a_d    = ent_a_q;
    ent_b_d    = ent_b_q;
    cos_d      = cos_q;
    sin_d      = sin_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          quad_d     = in_phase[15:14];
          x_lo_d     = in_phase[6:0];
          xc_d       = ~in_phase[13:0];
          rom_addr_d = in_phase[13:7];
          state_d    = LOOK0;
        end
      end
      LOOK0: begin
        rom_addr_d = xc_q[13:7];
        state_d    = LOOK1;
      end
      LOOK1: begin
        ent_a_d = rom_rdata;
        state_d = CAP;
      end
      CAP: begin
        ent_b_d = rom_rdata;
        state_d = CALC;
      end
      CALC: begin
        // Quadrant fold: the mirrored lookup f(x') supplies the complementary angle.
        unique case (quad_q)
          2'd0: begin cos_d = f_x;   sin_d = f_xc;  end
          2'd1: begin cos_d = -f_xc; sin_d = f_x;   end
          2'd2: begin cos_d = -f_x;  sin_d = -f_xc; end
          default: begin cos_d = f_xc; sin_d = -f_x; end
        endcase
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      quad_q     <= 2'd0;
      x_lo_q     <= 7'd0;
      xc_q       <= 14'd0;
      rom_addr_q <= 7'd0;
      ent_a_q    <= 31'd0;
      ent_b_q    <= 31'd0;
      cos_q      <= 20'd0;
      sin_q      <= 20'd0;
    end else begin
      state_q    <= state_d;
      quad_q     <= quad_d;
      x_lo_q     <= x_lo_d;
      xc_q       <= xc_d;
      rom_addr_q <= rom_addr_d;
      ent_a_q    <= ent_a_d;
      ent_b_q    <= ent_b_d;
      cos_q      <= cos_d;
      sin_q      <= sin_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign rom_addr  = rom_addr_q;
  assign out_cos   = cos_q;
  assign out_sin   = sin_q;

endmodule

// File: tb/tb_bm_cg_ctrl.sv
// Self-checking bench for bm_cg_ctrl: a synchronous ROM model, directed
// boundary phases, backpressure and mid-flight reset, then random traffic.
module tb_bm_cg_ctrl;

`ifdef BM_CG_CTRL_ROUND_EN
  localparam int Rnd    = 64;
  localparam int EdgeLo = 25;
`else
  localparam int Rnd    = 0;
  localparam int EdgeLo = 26;
`endif

  logic               clock = 1'b0;
  logic               reset_n;
  logic               in_valid;
  logic               in_ready;
  logic [15:0]        in_phase;
  logic [6:0]         rom_addr;
  logic [30:0]        rom_rdata;
  logic               out_valid;
  logic               out_ready;
  logic signed [19:0] out_cos;
  logic signed [19:0] out_sin;

  int n_checks = 0;
  int n_fail   = 0;

  int rom_base [128];
  int rom_drop [128];

  bm_cg_ctrl dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_phase  (in_phase),
    .rom_addr  (rom_addr),
    .rom_rdata (rom_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_cos   (out_cos),
    .out_sin   (out_sin)
  );

  always #5 clock = ~clock;

  always @(posedge clock) rom_rdata <= {19'(rom_base[rom_addr]), 12'(rom_drop[rom_addr])};

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Linear interpolation straight from the ROM table contents.
  function automatic int f_of(input logic [13:0] x);
    int idx, fr;
    idx = int'(x) / 128;
    fr  = int'(x) % 128;
    return rom_base[idx] - (rom_drop[idx] * fr + Rnd) / 128;
  endfunction

  function automatic void model(input logic [15:0] ph, output int c, output int s);
    int fx, fxc;
    fx  = f_of(ph[13:0]);
    fxc = f_of(~ph[13:0]);
    case (ph[15:14])
      2'd0:    begin c = fx;   s = fxc;  end
      2'd1:    begin c = -fxc; s = fx;   end
      2'd2:    begin c = -fx;  s = -fxc; end
      default: begin c = fxc;  s = -fx;  end
    endcase
  endfunction

  // One transaction; expects to start at a negedge. early: out_ready high from
  // accept. stall: cycles of out_ready=0 in DONE. pre: present nxt during stall.
  task automatic send(input logic [15:0] ph, input bit early, input int stall,
                      input bit pre, input logic [15:0] nxt,
                      output int oc, output int os);
    int n, ec, es;
    logic [13:0] xc;
    xc = ~ph[13:0];
    model(ph, ec, es);
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("in_ready_wait", int'(in_ready), 1);
    in_valid  = 1'b1;
    in_phase  = ph;
    out_ready = early;
    @(negedge clock);
    in_valid = 1'b0;
    check("addr_x", int'(rom_addr), int'(ph[13:7]));
    check("in_ready_busy", int'(in_ready), 0);
    @(negedge clock);
    check("addr_xc", int'(rom_addr), int'(xc[13:7]));
    repeat (2) begin
      @(negedge clock);
      check("valid_early", int'(out_valid), 0);
    end
    @(negedge clock);
    check("valid_latency", int'(out_valid), 1);
    oc = int'(out_cos);
    os = int'(out_sin);
    check("cos", oc, ec);
    check("sin", os, es);
    if (!early) begin
      for (int i = 0; i < stall; i++) begin
        if (pre) begin
          in_valid = 1'b1;
          in_phase = nxt;
        end
        @(negedge clock);
        check("hold_valid", int'(out_valid), 1);
        check("hold_in_ready", int'(in_ready), 0);
        check("hold_cos", int'(out_cos), ec);
        check("hold_sin", int'(out_sin), es);
      end
      out_ready = 1'b1;
    end
    @(negedge clock);
    check("valid_fall", int'(out_valid), 0);
    check("in_ready_rise", int'(in_ready), 1);
    out_ready = 1'b0;
  endtask

  initial begin
    int c, s;
    logic [15:0] ph [41];

    for (int i = 0; i < 128; i++) begin
      rom_base[i] = int'($urandom_range(524287, 4096));
      rom_drop[i] = int'($urandom_range(4095, 0));
    end
    rom_base[0]   = 262146;
    rom_drop[0]   = 20;
    rom_base[127] = 3217;
    rom_drop[127] = 3217;

    in_valid  = 1'b0;
    in_phase  = 16'h0;
    out_ready = 1'b0;
    reset_n   = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_valid", int'(out_valid), 0);
    check("rst_cos", int'(out_cos), 0);
    check("rst_sin", int'(out_sin), 0);
    check("rst_addr", int'(rom_addr), 0);
    reset_n = 1'b1;
    @(negedge clock);
    check("rst_in_ready", int'(in_ready), 1);

    send(16'h0000, 1'b1, 0, 1'b0, 16'h0, c, s);
    check("p0000_cos", c, 262146);
    check("p0000_sin", s, EdgeLo);
    send(16'h0040, 1'b0, 1, 1'b0, 16'h0, c, s);
    check("p0040_cos", c, 262136);
    check("p0040_sin", s, 1634);
    send(16'h4000, 1'b1, 0, 1'b0, 16'h0, c, s);
    check("p4000_cos", c, -EdgeLo);
    check("p4000_sin", s, 262146);
    send(16'h8000, 1'b0, 2, 1'b0, 16'h0, c, s);
    check("p8000_cos", c, -262146);
    check("p8000_sin", s, -EdgeLo);
    send(16'hC000, 1'b1, 0, 1'b0, 16'h0, c, s);
    check("pC000_cos", c, EdgeLo);
    check("pC000_sin", s, -262146);
    send(16'h3FFF, 1'b0, 0, 1'b0, 16'h0, c, s);
    check("p3FFF_cos", c, EdgeLo);
    check("p3FFF_sin", s, 262146);

    // Backpressure with the next phase already presented.
    send(16'h1234, 1'b0, 10, 1'b1, 16'h5678, c, s);
    send(16'h5678, 1'b0, 0, 1'b0, 16'h0, c, s);

    // Reset while in LOOK1 discards the in-flight phase.
    in_valid = 1'b1;
    in_phase = 16'h9ABC;
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_cos", int'(out_cos), 0);
    check("mid_rst_sin", int'(out_sin), 0);
    check("mid_rst_addr", int'(rom_addr), 0);
    check("mid_rst_idle", int'(in_ready), 1);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (6) begin
      @(negedge clock);
      check("mid_rst_no_out", int'(out_valid), 0);
    end
    send(16'h2345, 1'b0, 1, 1'b0, 16'h0, c, s);

    for (int i = 0; i < 41; i++) begin
      case ($urandom_range(5, 0))
        0:       ph[i] = {2'($urandom_range(3, 0)), 14'h0000};
        1:       ph[i] = {2'($urandom_range(3, 0)), 14'h3FFF};
        default: ph[i] = 16'($urandom);
      endcase
    end
    for (int i = 0; i < 40; i++) begin
      send(ph[i], ($urandom_range(3, 0) == 0), int'($urandom_range(4, 0)),
           1'($urandom_range(1, 0)), ph[i+1], c, s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
